// File: rtl/geofence_pkg.sv
// Shared geofence types: point constants, point struct and driver FSM states.
// Used by the geofence driver RTL and by geofence benches.
package geofence_pkg;

   localparam int COORD_W = 10;
   localparam int NPTS    = 7;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } point_t;

   typedef enum logic [1:0] {
      ST_SEND = 2'd0,
      ST_WAIT = 2'd1,
      ST_HALT = 2'd2
   } drv_state_t;

endpackage

// File: rtl/geofence_pt_buf.sv
// NPTS-entry point staging buffer: sequential fill via wp, whole-buffer release,
// combinational read port addressed by the driver's send index.
module geofence_pt_buf
   import geofence_pkg::*;
#(
   parameter int  COORD_W = geofence_pkg::COORD_W,
   parameter int  NPTS    = geofence_pkg::NPTS,
   localparam int IW      = (NPTS > 1) ? $clog2(NPTS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_i,
   input  logic [COORD_W-1:0] wr_x_i,
   input  logic [COORD_W-1:0] wr_y_i,
   input  logic               free_i,
   input  logic [IW-1:0]      rd_idx_i,
   output logic [COORD_W-1:0] rd_x_o,
   output logic [COORD_W-1:0] rd_y_o,
   output logic               full_o
);

   localparam logic [IW-1:0] WP_LAST = IW'(NPTS - 1);

   logic [COORD_W-1:0] buf_x_q [NPTS];
   logic [COORD_W-1:0] buf_y_q [NPTS];
   logic [IW-1:0]      wp_q;
   logic               full_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp_q   <= '0;
         full_q <= 1'b0;
         for (int i = 0; i < NPTS; i++) begin
            buf_x_q[i] <= '0;
            buf_y_q[i] <= '0;
         end
      end else if (wr_i && !full_q) begin
         buf_x_q[wp_q] <= wr_x_i;
         buf_y_q[wp_q] <= wr_y_i;
         if (wp_q == WP_LAST) begin
            wp_q   <= '0;
            full_q <= 1'b1;
         end else begin
            wp_q <= wp_q + 1'b1;
         end
      end else if (free_i) begin
         full_q <= 1'b0;
      end
   end

   assign rd_x_o = (rd_idx_i <= WP_LAST) ? buf_x_q[rd_idx_i] : '0;
   assign rd_y_o = (rd_idx_i <= WP_LAST) ? buf_y_q[rd_idx_i] : '0;
   assign full_o = full_q;

endmodule

// File: rtl/geofence_driver.sv
// Point-stream transmitter for the geofence engine; optional watchdog/HALT is
// enabled by defining GEOFENCE_DRV_TIMEOUT_EN.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_SEND | drive point idx (real set or zero bubble set), idx 0..NPTS-1
//  ST_WAIT | wait for engine valid, capture result of a real set
//  ST_HALT | watchdog expired; outputs parked until reset (macro only)
module geofence_driver
   import geofence_pkg::*;
#(
   parameter int COORD_W = geofence_pkg::COORD_W,
   parameter int NPTS    = geofence_pkg::NPTS,
   parameter int TIMEOUT = 31
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COORD_W-1:0] in_x,
   input  logic [COORD_W-1:0] in_y,
   output logic [COORD_W-1:0] gf_x,
   output logic [COORD_W-1:0] gf_y,
   input  logic               gf_valid,
   input  logic               gf_is_inside,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               res_inside,
   output logic               err_timeout
);

   localparam int            IW       = (NPTS > 1) ? $clog2(NPTS) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NPTS - 1);

   drv_state_t         state_q;
   logic [IW-1:0]      idx_q;
   logic               real_q;
   logic               res_valid_q;
   logic               res_inside_q;
   logic               full;
   logic               launch;
   logic               set_real;
   logic               send_real;
   logic               wr_en;
   logic               free_en;
   logic [COORD_W-1:0] rd_x;
   logic [COORD_W-1:0] rd_y;

   // Launch is decided on the registered result slot, so a same-cycle
   // handshake still produces a bubble for this set.
   assign launch    = full & ~res_valid_q;
   assign set_real  = (idx_q == '0) ? launch : real_q;
   assign send_real = (state_q == ST_SEND) && set_real;
   assign free_en   = send_real && (idx_q == IDX_LAST);
   assign in_ready  = ~full && (state_q != ST_HALT);
   assign wr_en     = in_valid & in_ready;

   geofence_pt_buf #(
      .COORD_W (COORD_W),
      .NPTS    (NPTS)
   ) u_buf (
      .clk      (clk),
      .reset    (reset),
      .wr_i     (wr_en),
      .wr_x_i   (in_x),
      .wr_y_i   (in_y),
      .free_i   (free_en),
      .rd_idx_i (idx_q),
      .rd_x_o   (rd_x),
      .rd_y_o   (rd_y),
      .full_o   (full)
   );

   assign gf_x = send_real ? rd_x : '0;
   assign gf_y = send_real ? rd_y : '0;

`ifdef GEOFENCE_DRV_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wcnt_q;
   logic          err_q;
   assign err_timeout = err_q;
`else
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_SEND;
         idx_q        <= '0;
         real_q       <= 1'b0;
         res_valid_q  <= 1'b0;
         res_inside_q <= 1'b0;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
         wcnt_q       <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
         end
         case (state_q)
            ST_SEND: begin
               if (idx_q == '0) begin
                  real_q <= launch;
               end
               if (idx_q == IDX_LAST) begin
                  idx_q   <= '0;
                  state_q <= ST_WAIT;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
                  wcnt_q  <= '0;
`endif
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            ST_WAIT: begin
               if (gf_valid) begin
                  state_q <= ST_SEND;
                  if (real_q) begin
                     res_valid_q  <= 1'b1;
                     res_inside_q <= gf_is_inside;
                  end
               end
`ifdef GEOFENCE_DRV_TIMEOUT_EN
               else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= ST_HALT;
               end else begin
                  wcnt_q <= wcnt_q + 1'b1;
               end
`endif
            end
`ifdef GEOFENCE_DRV_TIMEOUT_EN
            ST_HALT: state_q <= ST_HALT;
`endif
            default: state_q <= ST_SEND;
         endcase
      end
   end

   assign res_valid  = res_valid_q;
   assign res_inside = res_inside_q;

endmodule

// File: tb/tb_geofence_driver.sv
// Directed bench for geofence_driver against a cycle-accurate behavioural engine
// (7 load, gf_valid on cycle 23, convex-hexagon inside test).
`timescale 1ns/1ps
module tb_geofence_driver;
   import geofence_pkg::*;

   logic               clk       = 1'b0;
   logic               reset     = 1'b0;
   logic               in_valid  = 1'b0;
   logic               res_ready = 1'b0;
   logic               stub_mute = 1'b0;
   logic [COORD_W-1:0] in_x      = '0;
   logic [COORD_W-1:0] in_y      = '0;
   logic               in_ready;
   logic [COORD_W-1:0] gf_x;
   logic [COORD_W-1:0] gf_y;
   logic               gf_valid;
   logic               gf_is_inside;
   logic               res_valid;
   logic               res_inside;
   logic               err_timeout;

   int n_checks = 0;
   int n_errors = 0;

   point_t fence [6] = '{'{10'd50, 10'd50}, '{10'd150, 10'd50}, '{10'd200, 10'd100},
                         '{10'd150, 10'd150}, '{10'd50, 10'd150}, '{10'd0, 10'd100}};

   always #5 clk = ~clk;

   geofence_driver dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_x         (in_x),
      .in_y         (in_y),
      .gf_x         (gf_x),
      .gf_y         (gf_y),
      .gf_valid     (gf_valid),
      .gf_is_inside (gf_is_inside),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_inside   (res_inside),
      .err_timeout  (err_timeout)
   );

   // behavioural engine: loads on counts 0..6, reports on count 22
   int                 gcnt;
   logic [COORD_W-1:0] sx [NPTS];
   logic [COORD_W-1:0] sy [NPTS];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         gcnt <= 0;
         for (int i = 0; i < NPTS; i++) begin
            sx[i] <= '0;
            sy[i] <= '0;
         end
      end else begin
         if (gcnt < NPTS) begin
            sx[gcnt] <= gf_x;
            sy[gcnt] <= gf_y;
         end
         gcnt <= (gcnt == 22) ? 0 : gcnt + 1;
      end
   end

   assign gf_valid = (gcnt == 22) && !stub_mute;

   always_comb begin
      int ax, ay, bx, by, cr;
      gf_is_inside = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ax = int'(sx[i + 1]);
         ay = int'(sy[i + 1]);
         bx = int'(sx[(i + 1) % 6 + 1]);
         by = int'(sy[(i + 1) % 6 + 1]);
         cr = (bx - ax) * (int'(sy[0]) - ay) - (by - ay) * (int'(sx[0]) - ax);
         if (cr <= 0) gf_is_inside = 1'b0;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_point(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
      int guard = 0;
      in_valid = 1'b1;
      in_x     = x;
      in_y     = y;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check_val("push_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic push_job(input logic [COORD_W-1:0] ox, input logic [COORD_W-1:0] oy);
      push_point(ox, oy);
      for (int i = 0; i < 6; i++) push_point(fence[i].x, fence[i].y);
   endtask

   task automatic wait_res(input string tag);
      int guard = 0;
      while (!res_valid && guard < 120) begin
         @(negedge clk);
         guard++;
      end
      check_val({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
      check_val({tag, "_align"}, gcnt, 32'd0);
   endtask

   task automatic wait_gcnt(input int v);
      int guard = 0;
      while (gcnt != v && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check_val("sync", gcnt, v);
   endtask

   task automatic ack();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check_val("ack_clears", {31'd0, res_valid}, 32'd0);
   endtask

   task automatic quiet_run(input int n, output int nz, output int rv);
      nz = 0;
      rv = 0;
      repeat (n) begin
         @(negedge clk);
         if (gf_x != '0 || gf_y != '0) nz++;
         if (res_valid) rv++;
      end
   endtask

   initial begin
      int nz, rv;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("rst_gf_x", {22'd0, gf_x}, 32'd0);
      check_val("rst_gf_y", {22'd0, gf_y}, 32'd0);
      check_val("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check_val("rst_res_inside", {31'd0, res_inside}, 32'd0);
      check_val("rst_err", {31'd0, err_timeout}, 32'd0);
      reset = 1'b0;

      quiet_run(100, nz, rv);
      check_val("bubble_coords", nz, 32'd0);
      check_val("bubble_no_res", rv, 32'd0);

      push_job(10'd100, 10'd100);
      wait_res("jobA");
      check_val("jobA_inside", {31'd0, res_inside}, 32'd1);
      ack();

      push_job(10'd300, 10'd300);
      wait_res("jobB");
      check_val("jobB_inside", {31'd0, res_inside}, 32'd0);
      ack();

      // backpressure: two jobs with the result channel stalled
      push_job(10'd100, 10'd100);
      push_job(10'd300, 10'd300);
      check_val("bp_full_ready", {31'd0, in_ready}, 32'd0);
      wait_res("jobC");
      check_val("jobC_inside", {31'd0, res_inside}, 32'd1);
      quiet_run(50, nz, rv);
      check_val("bp_no_launch", nz, 32'd0);
      check_val("bp_hold_valid", rv, 32'd50);
      check_val("bp_hold_inside", {31'd0, res_inside}, 32'd1);
      check_val("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      ack();
      wait_res("jobD");
      check_val("jobD_inside", {31'd0, res_inside}, 32'd0);
      ack();

      // watchdog: engine never reports
      wait_gcnt(0);
      stub_mute = 1'b1;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
      repeat (37) @(negedge clk);
      check_val("to_before", {31'd0, err_timeout}, 32'd0);
      @(negedge clk);
      check_val("to_err", {31'd0, err_timeout}, 32'd1);
      check_val("to_in_ready", {31'd0, in_ready}, 32'd0);
      quiet_run(30, nz, rv);
      check_val("halt_coords", nz, 32'd0);
      check_val("halt_sticky", {31'd0, err_timeout}, 32'd1);
      stub_mute = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_val("halt_rst_err", {31'd0, err_timeout}, 32'd0);
`else
      quiet_run(60, nz, rv);
      check_val("nowd_err", {31'd0, err_timeout}, 32'd0);
      check_val("nowd_no_res", rv, 32'd0);
      stub_mute = 1'b0;
      push_job(10'd100, 10'd100);
      wait_res("jobE");
      check_val("jobE_inside", {31'd0, res_inside}, 32'd1);
      ack();
`endif

      // reset in the middle of a real set
      push_job(10'd100, 10'd100);
      wait_gcnt(0);
      wait_gcnt(3);
      check_val("mid_gf_x", {22'd0, gf_x}, 32'd200);
      check_val("mid_gf_y", {22'd0, gf_y}, 32'd100);
      reset = 1'b1;
      #1;
      check_val("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("mid_rst_gf_x", {22'd0, gf_x}, 32'd0);
      check_val("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
      check_val("mid_rst_err", {31'd0, err_timeout}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      quiet_run(60, nz, rv);
      check_val("post_rst_bubble", nz, 32'd0);
      check_val("post_rst_no_res", rv, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, errors so far %0d", n_errors);
      $fatal(1);
   end

endmodule
